// File: rtl/input_debouncer.sv
// Debouncer for a raw asynchronous input: synchronizer chain, stability counter,
// registered edge strobes and a saturating count of rejected glitches.
module input_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_raw,
   output logic                a_clean,
   output logic                rise,
   output logic                fall,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_out;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [GLITCH_W-1:0]    glitch_q, glitch_d;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], a_raw};
      cnt_d    = cnt_q;
      clean_d  = clean_q;
      glitch_d = glitch_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (sync_out == clean_q) begin
         // Falling back to the accepted level with a partial count is a rejected glitch.
         if (cnt_q != '0) begin
            cnt_d = '0;
            if (glitch_q != '1) begin
               glitch_d = glitch_q + 1'b1;
            end
         end
      end else if (cnt_q == CntLast) begin
         clean_d = sync_out;
         cnt_d   = '0;
         rise_d  = sync_out;
         fall_d  = ~sync_out;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         clean_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign a_clean    = clean_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign glitch_cnt = glitch_q;

endmodule
